// File: rtl/awg_pkg.sv
// Shared constants, widths and types for the AWG control plane.
package awg_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned FREQ_W  = 12;
  localparam int unsigned AMP_W   = 3;
  localparam int unsigned PHASE_W = 8;

  localparam logic [BYTE_W-1:0] HDR_BYTE     = 8'hA5;
  localparam logic [BYTE_W-1:0] CMD_DEFAULTS = 8'h00;
  localparam logic [BYTE_W-1:0] CMD_FREQ     = 8'h01;
  localparam logic [BYTE_W-1:0] CMD_AMP      = 8'h02;
  localparam logic [BYTE_W-1:0] CMD_PHASE    = 8'h03;
  localparam logic [BYTE_W-1:0] CMD_ENABLE   = 8'h04;

  // Frame parser states; GOT_x means byte x has been captured.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GOT_HDR = 3'd1,
    ST_GOT_CMD = 3'd2,
    ST_GOT_HI  = 3'd3,
    ST_GOT_LO  = 3'd4
  } awg_state_e;

  // Generator control register set, updated as one unit.
  typedef struct packed {
    logic               en;
    logic [FREQ_W-1:0]  freq;
    logic [AMP_W-1:0]   amp;
    logic [PHASE_W-1:0] phase;
  } awg_regs_t;

  // Expected checksum byte of a frame.
  function automatic logic [BYTE_W-1:0] frame_chk(
    input logic [BYTE_W-1:0] cmd,
    input logic [BYTE_W-1:0] d_hi,
    input logic [BYTE_W-1:0] d_lo
  );
    return cmd ^ d_hi ^ d_lo;
  endfunction

endpackage

// File: rtl/awg_cmd_ctrl.sv
// Command-frame parser and control-register bank for the sine generator.
module awg_cmd_ctrl
  import awg_pkg::*;
#(
  parameter int unsigned          TIMEOUT_CYC = 5_000_000,
  parameter logic [FREQ_W-1:0]    FREQ_RST    = 12'd64,
  parameter logic [AMP_W-1:0]     AMP_RST     = 3'd1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BYTE_W-1:0]   rx_data,
  input  logic                rx_valid,
  output logic                en,
  output logic [FREQ_W-1:0]   freq,
  output logic [AMP_W-1:0]    amp,
  output logic [PHASE_W-1:0]  phase,
  output logic                cmd_ok,
  output logic                cmd_err,
  output logic                busy
);

  localparam int unsigned    CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam awg_regs_t      REGS_RST = '{en: 1'b0, freq: FREQ_RST, amp: AMP_RST, phase: '0};

  awg_state_e          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [BYTE_W-1:0]   r_cmd;
  logic [BYTE_W-1:0]   r_dhi;
  logic [BYTE_W-1:0]   r_dlo;
  awg_regs_t           r_regs;
  logic                r_cmd_ok;
  logic                r_cmd_err;
  logic                r_busy;

  awg_state_e          w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [BYTE_W-1:0]   w_cmd_nxt;
  logic [BYTE_W-1:0]   w_dhi_nxt;
  logic [BYTE_W-1:0]   w_dlo_nxt;
  awg_regs_t           w_regs_nxt;
  logic                w_ok_nxt;
  logic                w_err_nxt;

  logic [2*BYTE_W-1:0] w_data;
  awg_regs_t           w_cand;
  logic                w_legal;
  logic                w_chk_ok;
  logic                w_timeout;

  assign w_data    = {r_dhi, r_dlo};
  assign w_chk_ok  = (rx_data == frame_chk(r_cmd, r_dhi, r_dlo));
  assign w_timeout = !rx_valid && (r_state != ST_IDLE) && (r_cnt == CNT_LAST);

  // Decode the captured command into a candidate register set and legality flag.
  always_comb begin
    w_cand  = r_regs;
    w_legal = 1'b0;
    case (r_cmd)
      CMD_DEFAULTS: begin
        w_cand  = REGS_RST;
        w_legal = 1'b1;
      end
      CMD_FREQ: begin
        if (r_dhi[7:4] == 4'h0) begin
          w_cand.freq = w_data[FREQ_W-1:0];
          w_legal     = 1'b1;
        end
      end
      CMD_AMP: begin
        if ((w_data != 16'd0) && (w_data <= 16'd7)) begin
          w_cand.amp = w_data[AMP_W-1:0];
          w_legal    = 1'b1;
        end
      end
      CMD_PHASE: begin
        w_cand.phase = r_dlo;
        w_legal      = 1'b1;
      end
      CMD_ENABLE: begin
        w_cand.en = r_dlo[0];
        w_legal   = 1'b1;
      end
      default: begin
        w_cand  = r_regs;
        w_legal = 1'b0;
      end
    endcase
  end

  // Next-state, byte capture, timeout counting and apply/reject decision.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_cmd_nxt   = r_cmd;
    w_dhi_nxt   = r_dhi;
    w_dlo_nxt   = r_dlo;
    w_regs_nxt  = r_regs;
    w_ok_nxt    = 1'b0;
    w_err_nxt   = 1'b0;

    if (rx_valid) begin
      // An arriving byte always restarts the inter-byte timer and beats a timeout.
      case (r_state)
        ST_IDLE: begin
          if (rx_data == HDR_BYTE) w_state_nxt = ST_GOT_HDR;
        end
        ST_GOT_HDR: begin
          w_cmd_nxt   = rx_data;
          w_state_nxt = ST_GOT_CMD;
        end
        ST_GOT_CMD: begin
          w_dhi_nxt   = rx_data;
          w_state_nxt = ST_GOT_HI;
        end
        ST_GOT_HI: begin
          w_dlo_nxt   = rx_data;
          w_state_nxt = ST_GOT_LO;
        end
        ST_GOT_LO: begin
          w_state_nxt = ST_IDLE;
          if (w_chk_ok && w_legal) begin
            w_regs_nxt = w_cand;
            w_ok_nxt   = 1'b1;
          end else begin
            w_err_nxt  = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end else if (w_timeout) begin
      w_state_nxt = ST_IDLE;
      w_err_nxt   = 1'b1;
    end else if (r_state != ST_IDLE) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_cmd     <= '0;
      r_dhi     <= '0;
      r_dlo     <= '0;
      r_regs    <= REGS_RST;
      r_cmd_ok  <= 1'b0;
      r_cmd_err <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_cmd     <= w_cmd_nxt;
      r_dhi     <= w_dhi_nxt;
      r_dlo     <= w_dlo_nxt;
      r_regs    <= w_regs_nxt;
      r_cmd_ok  <= w_ok_nxt;
      r_cmd_err <= w_err_nxt;
      r_busy    <= (w_state_nxt != ST_IDLE);
    end
  end

  assign en      = r_regs.en;
  assign freq    = r_regs.freq;
  assign amp     = r_regs.amp;
  assign phase   = r_regs.phase;
  assign cmd_ok  = r_cmd_ok;
  assign cmd_err = r_cmd_err;
  assign busy    = r_busy;

endmodule

// File: tb/tb_awg_cmd_ctrl.sv
// Randomized bench for awg_cmd_ctrl with a frame-level reference model.
module tb_awg_cmd_ctrl;

  localparam int unsigned TO       = 20;
  localparam logic [11:0] FREQ_RST = 12'd64;
  localparam logic [2:0]  AMP_RST  = 3'd1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        en;
  logic [11:0] freq;
  logic [2:0]  amp;
  logic [7:0]  phase;
  logic        cmd_ok;
  logic        cmd_err;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  awg_cmd_ctrl #(
    .TIMEOUT_CYC (TO),
    .FREQ_RST    (FREQ_RST),
    .AMP_RST     (AMP_RST)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .en       (en),
    .freq     (freq),
    .amp      (amp),
    .phase    (phase),
    .cmd_ok   (cmd_ok),
    .cmd_err  (cmd_err),
    .busy     (busy)
  );

  // Reference model: collects frame bytes in a queue and applies the command rules.
  logic        m_en, m_ok, m_err, m_busy;
  logic [11:0] m_freq;
  logic [2:0]  m_amp;
  logic [7:0]  m_phase;
  logic [7:0]  fr[$];
  int          edge_n = 0;
  int          last_edge = 0;

  task automatic apply_frame();
    logic [7:0] c, h, l, k;
    int d;
    bit good;
    c = fr[1]; h = fr[2]; l = fr[3]; k = fr[4];
    d = int'(h) * 256 + int'(l);
    good = 1'b1;
    if ((c ^ h ^ l) != k) good = 1'b0;
    else if (c == 8'h00) begin
      m_en = 1'b0; m_freq = FREQ_RST; m_amp = AMP_RST; m_phase = 8'h00;
    end else if (c == 8'h01) begin
      if (d < 4096) m_freq = 12'(d); else good = 1'b0;
    end else if (c == 8'h02) begin
      if (d >= 1 && d <= 7) m_amp = 3'(d); else good = 1'b0;
    end else if (c == 8'h03) m_phase = l;
    else if (c == 8'h04) m_en = l[0];
    else good = 1'b0;
    m_ok  = good;
    m_err = !good;
  endtask

  always @(posedge clk) begin
    edge_n++;
    m_ok  = 1'b0;
    m_err = 1'b0;
    if (rst) begin
      m_en = 1'b0; m_freq = FREQ_RST; m_amp = AMP_RST; m_phase = 8'h00;
      fr.delete();
    end else if (rx_valid) begin
      last_edge = edge_n;
      if (fr.size() != 0 || rx_data == 8'hA5) fr.push_back(rx_data);
      if (fr.size() == 5) begin
        apply_frame();
        fr.delete();
      end
    end else if (fr.size() != 0 && (edge_n - last_edge) >= int'(TO)) begin
      m_err = 1'b1;
      fr.delete();
    end
    m_busy = (fr.size() != 0);
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(posedge clk) begin
    #1;
    vectors++;
    if ({en, freq, amp, phase, cmd_ok, cmd_err, busy} !==
        {m_en, m_freq, m_amp, m_phase, m_ok, m_err, m_busy}) begin
      miscompares++;
      $display("FAIL cycle %0d outputs: got en=%0d freq=%03h amp=%0d phase=%02h ok=%0d err=%0d busy=%0d, want en=%0d freq=%03h amp=%0d phase=%02h ok=%0d err=%0d busy=%0d",
               edge_n, en, freq, amp, phase, cmd_ok, cmd_err, busy,
               m_en, m_freq, m_amp, m_phase, m_ok, m_err, m_busy);
    end
  end

  task automatic pin(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic drive_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
    end
  endtask

  task automatic idle_edge();
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2, b3, b4);
    drive_byte(b0, 0); drive_byte(b1, 0); drive_byte(b2, 0);
    drive_byte(b3, 0); drive_byte(b4, 0);
    idle_edge();
  endtask

  task automatic rand_traffic();
    logic [7:0] b [5];
    logic [7:0] g;
    int mode, n;
    if ($urandom_range(0, 4) == 0) begin
      g = 8'($urandom);
      if (g == 8'hA5) g = 8'h00;
      drive_byte(g, $urandom_range(0, 2));
    end
    b[0] = 8'hA5;
    case ($urandom_range(0, 9))
      0:       b[1] = 8'h00;
      1, 2:    b[1] = 8'h01;
      3, 4:    b[1] = 8'h02;
      5:       b[1] = 8'h03;
      6:       b[1] = 8'h04;
      7:       b[1] = 8'hA5;
      8:       b[1] = 8'h05;
      default: b[1] = 8'($urandom);
    endcase
    b[2] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
    b[3] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 9)) : 8'($urandom);
    b[4] = b[1] ^ b[2] ^ b[3];
    if ($urandom_range(0, 7) == 0) b[4] = b[4] ^ 8'($urandom_range(1, 255));
    mode = $urandom_range(0, 29);
    n = (mode <= 1) ? $urandom_range(1, 4) : 5;
    for (int i = 0; i < n; i++)
      drive_byte(b[i], ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    idle_edge();
    if (mode == 0) repeat (TO + $urandom_range(0, 3)) idle_edge();
    if (mode == 1) begin
      rst = 1'b1;
      idle_edge();
      rst = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    pin("rst en", en, 0);       pin("rst freq", freq, 12'h040);
    pin("rst amp", amp, 1);     pin("rst phase", phase, 0);
    pin("rst busy", busy, 0);   pin("rst ok", cmd_ok, 0);
    pin("rst err", cmd_err, 0);

    send_frame(8'hA5, 8'h01, 8'h01, 8'h00, 8'h00);
    pin("freq ok", cmd_ok, 1);  pin("freq val", freq, 12'h100);
    pin("freq en", en, 0);      pin("freq amp", amp, 1);
    idle_edge();
    pin("ok one clk", cmd_ok, 0);

    send_frame(8'hA5, 8'h02, 8'h00, 8'h00, 8'h02);
    pin("amp0 err", cmd_err, 1); pin("amp0 ok", cmd_ok, 0); pin("amp0 hold", amp, 1);
    send_frame(8'hA5, 8'h02, 8'h00, 8'h05, 8'h07);
    pin("amp5 ok", cmd_ok, 1);   pin("amp5 val", amp, 5);

    send_frame(8'hA5, 8'h03, 8'h00, 8'h40, 8'h43);
    pin("phase ok", cmd_ok, 1);  pin("phase val", phase, 8'h40);
    send_frame(8'hA5, 8'h04, 8'h00, 8'h01, 8'h05);
    pin("en ok", cmd_ok, 1);     pin("en val", en, 1);

    send_frame(8'hA5, 8'h01, 8'h10, 8'h00, 8'h11);
    pin("nibble err", cmd_err, 1); pin("nibble hold", freq, 12'h100);
    send_frame(8'hA5, 8'h01, 8'h01, 8'h00, 8'hFF);
    pin("chk err", cmd_err, 1);  pin("chk no ok", cmd_ok, 0);

    drive_byte(8'hA5, 0); drive_byte(8'h01, 0);
    idle_edge();
    repeat (TO - 1) idle_edge();
    pin("to early err", cmd_err, 0); pin("to early busy", busy, 1);
    idle_edge();
    pin("to err", cmd_err, 1);   pin("to busy", busy, 0);
    idle_edge();
    pin("to single", cmd_err, 0);
    send_frame(8'hA5, 8'h01, 8'h02, 8'h34, 8'h37);
    pin("after to ok", cmd_ok, 1); pin("after to freq", freq, 12'h234);

    drive_byte(8'hA5, 0); drive_byte(8'h01, 0); drive_byte(8'h01, 0);
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pin("mid rst busy", busy, 0); pin("mid rst ok", cmd_ok, 0);
    pin("mid rst err", cmd_err, 0); pin("mid rst en", en, 0);
    pin("mid rst freq", freq, 12'h040); pin("mid rst amp", amp, 1);
    pin("mid rst phase", phase, 0);
    send_frame(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00);
    pin("defaults ok", cmd_ok, 1); pin("defaults freq", freq, 12'h040);

    repeat (400) rand_traffic();
    repeat (TO + 5) idle_edge();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
